// File: rtl/seg_display_mux.sv
// Scans a 32-bit hex value across an 8-digit common-anode 7-segment display,
// with post-switch anode blanking. Optional LEADING_ZERO_BLANK_EN suppresses leading zeros.
`timescale 1ns/1ps

module seg_display_mux #(
  parameter int BLANK_CYC = 8,
  parameter int BW        = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick,
  input  logic [31:0] data,
  input  logic [7:0]  dp_in,
  input  logic [7:0]  digit_en,
  output logic [7:0]  anode,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [2:0]  digit_sel
);

  localparam logic [BW-1:0] BLANK_INIT = BW'(BLANK_CYC);

  logic [2:0]    r_ptr;
  logic [BW-1:0] r_bcnt;
  logic [31:0]   r_data_q;
  logic [7:0]    r_dp_q;
  logic [7:0]    r_anode;
  logic [6:0]    r_seg;
  logic          r_dp;
  logic [2:0]    r_digit_sel;

  logic [7:0]    w_lz_blank;
  logic [3:0]    w_nib;
  logic          w_blank;

  function automatic logic [6:0] hex7(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
      4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
      4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
      4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // Scan pointer, blanking counter and per-frame snapshot of the displayed value.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr    <= 3'd0;
      r_bcnt   <= BLANK_INIT;
      r_data_q <= 32'h0;
      r_dp_q   <= 8'h0;
    end else if (tick) begin
      r_ptr  <= r_ptr + 3'd1;
      r_bcnt <= BLANK_INIT;
      if (r_ptr == 3'd7) begin
        r_data_q <= data;
        r_dp_q   <= dp_in;
      end
    end else if (r_bcnt != '0) begin
      r_bcnt <= r_bcnt - BW'(1);
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  // Walk down from the top digit; once a nonzero nibble or a requested point is seen, all lower digits show.
  always_comb begin
    logic keep;
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    w_lz_blank = 8'h00;
    keep       = 1'b0;
    for (int i = 7; i >= 1; i--) begin
      keep          = keep | (r_data_q[4*i +: 4] != 4'h0) | r_dp_q[i];
      w_lz_blank[i] = ~keep;
    end
  end
`else
  assign w_lz_blank = 8'h00;
`endif

  assign w_nib   = r_data_q[{r_ptr, 2'b00} +: 4];
  assign w_blank = (r_bcnt != '0) | ~digit_en[r_ptr] | w_lz_blank[r_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_anode     <= 8'hFF;
      r_seg       <= 7'h7F;
      r_dp        <= 1'b1;
      r_digit_sel <= 3'd0;
    end else begin
      r_anode     <= w_blank ? 8'hFF : ~(8'b1 << r_ptr);
      r_seg       <= w_blank ? 7'h7F : hex7(w_nib);
      r_dp        <= w_blank ? 1'b1 : ~r_dp_q[r_ptr];
      r_digit_sel <= r_ptr;
    end
  end

  assign anode     = r_anode;
  assign seg       = r_seg;
  assign dp        = r_dp;
  assign digit_sel = r_digit_sel;

endmodule

// File: tb/tb_seg_display_mux.sv
// Scoreboard bench for seg_display_mux: two instances (BLANK_CYC=0 and 3) share stimulus;
// expected outputs are queued per cycle when ticks are driven and compared on the falling edge.
`timescale 1ns/1ps

module tb_seg_display_mux;

  logic        clk = 1'b0;
  logic        rst;
  logic        tick;
  logic [31:0] data;
  logic [7:0]  dp_in;
  logic [7:0]  digit_en;

  logic [7:0] a0, a3;
  logic [6:0] s0, s3;
  logic       d0, d3;
  logic [2:0] sel0, sel3;

  int cyc    = 0;
  int n_cmp  = 0;
  int n_bad  = 0;

  typedef struct {
    int         cyc;
    int         dut;
    logic [7:0] an;
    logic [6:0] sg;
    logic       dp;
    logic [2:0] sel;
    string      tag;
  } exp_t;

  exp_t sb[$];

  // Reference state of the display, advanced by the bench on every tick it drives.
  logic [2:0]  m_ptr;
  logic [31:0] m_dq;
  logic [7:0]  m_dpq;

  logic [6:0] hex_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  seg_display_mux #(.BLANK_CYC(0), .BW(4)) dut0 (
    .clk(clk), .rst(rst), .tick(tick), .data(data), .dp_in(dp_in), .digit_en(digit_en),
    .anode(a0), .seg(s0), .dp(d0), .digit_sel(sel0)
  );

  seg_display_mux #(.BLANK_CYC(3), .BW(4)) dut3 (
    .clk(clk), .rst(rst), .tick(tick), .data(data), .dp_in(dp_in), .digit_en(digit_en),
    .anode(a3), .seg(s3), .dp(d3), .digit_sel(sel3)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Highest digit that must show: top nonzero nibble or top requested point.
  function automatic logic lz(input int p);
`ifdef LEADING_ZERO_BLANK_EN
    int top = 0;
    for (int i = 0; i < 8; i++)
      if (m_dq[4*i +: 4] != 4'h0 || m_dpq[i]) top = i;
    return p > top;
`else
    return (p < 0);
`endif
  endfunction

  task automatic push_fixed(input int dut, input int at, input logic [7:0] an,
                            input logic [6:0] sg, input logic d, input logic [2:0] sel,
                            input string kind);
    exp_t e;
    e.cyc = at; e.dut = dut; e.an = an; e.sg = sg; e.dp = d; e.sel = sel;
    e.tag = $sformatf("%s_d%0d_c%0d_p%0d", kind, dut, at, sel);
    sb.push_back(e);
  endtask

  task automatic push_rst(input int dut, input int at);
    push_fixed(dut, at, 8'hFF, 7'h7F, 1'b1, 3'd0, "rst");
  endtask

  task automatic push_blank(input int dut, input int at);
    push_fixed(dut, at, 8'hFF, 7'h7F, 1'b1, m_ptr, "blank");
  endtask

  task automatic push_disp(input int dut, input int at);
    int         p;
    logic [3:0] nib;
    logic       off;
    p   = int'(m_ptr);
    nib = m_dq[4*p +: 4];
    off = ~digit_en[p] | lz(p);
    if (off) push_fixed(dut, at, 8'hFF, 7'h7F, 1'b1, m_ptr, "dark");
    else     push_fixed(dut, at, ~(8'h01 << p), hex_tbl[nib], ~m_dpq[p], m_ptr, "disp");
  endtask

  task automatic model_tick();
    if (m_ptr == 3'd7) begin
      m_dq  = data;
      m_dpq = dp_in;
    end
    m_ptr = m_ptr + 3'd1;
  endtask

  // Called on a falling edge; one isolated tick, then gap-1 idle cycles.
  task automatic do_tick(input int gap);
    int c;
    tick = 1'b1;
    c    = cyc;
    model_tick();
    push_disp(0, c + 2);
    push_blank(1, c + 2);
    push_blank(1, c + 4);
    push_disp(0, c + 5);
    push_disp(1, c + 5);
    @(negedge clk);
    tick = 1'b0;
    repeat (gap - 1) @(negedge clk);
  endtask

  task automatic tick_burst(input int n);
    for (int k = 0; k < n; k++) begin
      tick = 1'b1;
      model_tick();
      push_disp(0, cyc + 2);
      push_blank(1, cyc + 2);
      @(negedge clk);
    end
    tick = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic release_reset();
    int r;
    rst   = 1'b0;
    tick  = 1'b0;
    m_ptr = 3'd0;
    m_dq  = 32'h0;
    m_dpq = 8'h0;
    r     = cyc;
    push_disp(0, r + 1);
    push_blank(1, r + 1);
    push_disp(1, r + 4);
    repeat (5) @(negedge clk);
  endtask

  always @(negedge clk) begin
    exp_t        e;
    logic [7:0]  an;
    logic [6:0]  sg;
    logic        d;
    logic [2:0]  sel;
    while (sb.size() != 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      if (e.cyc != cyc) check({e.tag, "_cyc"}, 32'(cyc), 32'(e.cyc));
      if (e.dut == 0) begin an = a0; sg = s0; d = d0; sel = sel0; end
      else            begin an = a3; sg = s3; d = d3; sel = sel3; end
      check({e.tag, "_anode"}, 32'(an),  32'(e.an));
      check({e.tag, "_seg"},   32'(sg),  32'(e.sg));
      check({e.tag, "_dp"},    32'(d),   32'(e.dp));
      check({e.tag, "_sel"},   32'(sel), 32'(e.sel));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d expectations pending", sb.size());
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 1'b1;
    tick     = 1'b1;
    data     = 32'h89ABCDEF;
    dp_in    = 8'h00;
    digit_en = 8'hFF;
    m_ptr    = 3'd0;
    m_dq     = 32'h0;
    m_dpq    = 8'h0;

    // Reset held with tick high.
    for (int i = 1; i <= 3; i++) begin
      push_rst(0, i);
      push_rst(1, i);
    end
    repeat (3) @(negedge clk);
    release_reset();

    // First frame shows the reset snapshot; the wrap loads 89ABCDEF for the next one.
    repeat (16) do_tick(6);

    // Back-to-back ticks keep the blanked instance dark while the pointer races.
    tick_burst(10);

    // Mid-frame data change is invisible until the next wrap.
    data = 32'h11111111;
    while (m_ptr != 3'd7) do_tick(6);
    do_tick(6);
    while (m_ptr != 3'd3) do_tick(6);
    data = 32'h22222222;
    while (m_ptr != 3'd7) do_tick(6);
    repeat (8) do_tick(6);

    // Disabled slot 3, decimal point on digit 0 only.
    digit_en = 8'b1111_0111;
    dp_in    = 8'h01;
    while (m_ptr != 3'd7) do_tick(6);
    repeat (8) do_tick(6);
    digit_en = 8'hFF;
    dp_in    = 8'h00;

    // Leading zeros: blanked only when the option is built in.
    data = 32'h0000_0A05;
    while (m_ptr != 3'd7) do_tick(6);
    repeat (8) do_tick(6);

    // Asynchronous reset mid-frame: outputs clear before the next rising edge.
    while (m_ptr != 3'd4) do_tick(6);
    @(posedge clk);
    #1;
    rst  = 1'b1;
    tick = 1'b1;
    push_rst(0, cyc);
    push_rst(1, cyc);
    push_rst(0, cyc + 1);
    push_rst(1, cyc + 1);
    push_rst(0, cyc + 2);
    push_rst(1, cyc + 2);
    repeat (3) @(negedge clk);
    release_reset();
    repeat (3) do_tick(6);

    repeat (10) @(negedge clk);
    check("sb_drain", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
